virtual_uart_fifo: RTL and testbench
====================================

VIRTUAL_UART_FIFO -- requirements
Module: virtual_uart_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning entries per TX/RX FIFO (power of two, 2..256).
REQ-002 SHALL have parameter CHAR_WIDTH, default 8, meaning character bits (1..32), zero-extended on reads.
REQ-003 SHALL have parameter TX_THRESH, default FIFO_DEPTH/2, meaning the reset value of the host-interrupt TX level.
REQ-004 SHALL have one clock and a synchronous, active-low reset, with ports listed first:
- clock_i  in  1  clock.
- reset_ni  in  1  synchronous active-low reset.
REQ-005 SHALL provide these interrupt ports:
- int_o  out  2  interrupt level outputs; bit 0 goes to the core, bit 1 goes to the XDMA host.
- int_ack_i  in  2  single-cycle interrupt acknowledge pulses, one per int_o bit.
REQ-006 SHALL provide these AXI-lite slave address and write-data ports:
- s_axilite_awaddr/araddr  in  32  byte addresses.
- s_axilite_awprot/arprot  in  3  protection bits, ignored.
- s_axilite_wdata  in  32  write data.
- s_axilite_wstrb  in  4  write strobes.
REQ-007 SHALL provide these AXI-lite response and read-data ports:
- s_axilite_bresp/rresp  out  2  responses.
- s_axilite_rdata  out  32  read data.
- valid/ready  1 bit each  for the aw, w, b, ar and r channels, with standard direction.

Function
REQ-008 SHALL decode address bits [4:2]; bits [31:5] and [1:0] SHALL be ignored. The register map is:
- 0x00 RX_DATA: core read, pops RX.
- 0x04 TX_DATA: core write, pushes TX.
- 0x08 STATUS: read-only.
- 0x0C CTRL: read/write.
- 0x10 HOST_TX: host read, pops TX.
- 0x14 HOST_RX: host write, pushes RX.
- 0x18 TX_LEVEL: read/write threshold.
- 0x1C: unmapped.
REQ-009 SHALL lay out STATUS as:
- [0] RX not empty.
- [1] RX full.
- [2] TX empty.
- [3] TX full.
- [4] overrun sticky.
- [5] int_o[0].
- [6] int_o[1].
- [23:16] TX count.
- [31:24] RX count.
REQ-010 SHALL lay out CTRL as:
- [0] IE_CORE.
- [1] IE_HOST.
- [2] TX FIFO reset (self-clearing, reads 0).
- [3] RX FIFO reset (self-clearing, reads 0).
- [4] overrun clear (self-clearing, reads 0).
REQ-011 SHALL handle writes as follows:
- awready and wready are asserted together, only when awvalid&&wvalid and no B response is pending.
- bvalid is asserted the following cycle and held until bready.
- aw or w arriving alone SHALL wait.
REQ-012 SHALL handle reads as follows:
- arready is asserted when no R response is pending.
- rvalid/rdata are asserted the following cycle and held stable until rready.
REQ-013 SHALL respond OKAY to all mapped accesses, DECERR to 0x1C, and SLVERR to reads of write-only or writes of read-only registers.
REQ-014 SHALL commit the side effects of a DECERR or SLVERR access as none.
REQ-015 SHALL ignore wstrb for FIFO pushes, which use wdata[CHAR_WIDTH-1:0]; CTRL and TX_LEVEL SHALL honour wstrb[0].
REQ-016 SHALL treat a push to a full FIFO as follows: data dropped, overrun bit set, response OKAY.
REQ-017 SHALL treat a pop of an empty FIFO as follows: rdata 0, no pointer change, response OKAY.
REQ-018 SHALL give each FIFO:
- log2(FIFO_DEPTH)-bit wrapping read/write pointers.
- a (log2(FIFO_DEPTH)+1)-bit count.
- pointer wrap from FIFO_DEPTH-1 to 0 without gaps.
REQ-019 SHALL give pop data a latency of exactly one cycle from ar handshake to rvalid, including when the read hits the FIFO head.
REQ-020 SHALL implement each interrupt bit as a FSM IDLE -> PENDING -> IDLE:
- int_o is 1 exactly in PENDING.
- int_ack_i alone SHALL return the FSM to IDLE.
REQ-021 SHALL move int_o[0] IDLE->PENDING when IE_CORE && RX count transitions 0->nonzero.
REQ-022 SHALL move int_o[1] IDLE->PENDING when IE_HOST && TX count rises to >= TX_LEVEL.
REQ-023 SHALL treat an ack coinciding with a new trigger as: return to IDLE, then re-enter PENDING on the next cycle only if the trigger condition re-fires.
REQ-024 SHALL apply a TX or RX FIFO reset bit in the cycle after the write handshake: pointers and count are cleared, and the FIFO contents are not cleared.

Reset
REQ-025 SHALL, while reset_ni=0 at a rising clock_i, clear all of the following:
- awready, wready, arready, bvalid, rvalid, rdata, bresp, rresp.
- int_o, both FSMs, FIFO pointers and counts, overrun, CTRL.
REQ-026 SHALL load TX_LEVEL with TX_THRESH at reset.
REQ-027 SHALL, if reset is asserted mid-transaction, abandon the pending B or R response; the master must reissue it.

Verification
REQ-028 SHALL cover this scenario: write 0x41,0x42 to 0x04 then read 0x10 twice -> rdata 0x41 then 0x42, with STATUS[2]=1 afterwards.
REQ-029 SHALL cover this scenario: FIFO_DEPTH=16, 17 writes to 0x04 -> STATUS[3]=1, STATUS[4]=1, TX count 16, and 16 host reads return the first 16 values.
REQ-030 SHALL cover this scenario: CTRL=0x1, host writes 0x55 to 0x14 -> int_o[0]=1 one cycle later; int_ack_i[0] pulse -> int_o[0]=0; core read of 0x00 returns 0x55.
REQ-031 SHALL cover this scenario: CTRL=0x2, TX_LEVEL=4, push 4 chars -> int_o[1] rises on the 4th push; ack plus a 5th push in the same cycle -> int_o[1]=0 and stays 0.
REQ-032 SHALL cover this scenario: read 0x1C -> rresp=DECERR; read 0x04 -> rresp=SLVERR; awvalid without wvalid for 10 cycles -> no awready.
REQ-033 SHALL cover this scenario: reset_ni=0 for one cycle while rvalid is pending -> rvalid=0, STATUS reads 0x00000004, and TX_LEVEL reads TX_THRESH.

Source files
------------

// File: rtl/virtual_uart_fifo.sv
// Virtual UART: paired TX/RX character FIFOs between a core and an XDMA host,
// exposed through one AXI-lite slave, with one level interrupt per side.
module virtual_uart_fifo #(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned CHAR_WIDTH = 8,
  parameter int unsigned TX_THRESH  = FIFO_DEPTH / 2
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  output logic [1:0]  int_o,
  input  logic [1:0]  int_ack_i,
  input  logic [31:0] s_axilite_awaddr,
  input  logic [2:0]  s_axilite_awprot,
  input  logic        s_axilite_awvalid,
  output logic        s_axilite_awready,
  input  logic [31:0] s_axilite_wdata,
  input  logic [3:0]  s_axilite_wstrb,
  input  logic        s_axilite_wvalid,
  output logic        s_axilite_wready,
  output logic [1:0]  s_axilite_bresp,
  output logic        s_axilite_bvalid,
  input  logic        s_axilite_bready,
  input  logic [31:0] s_axilite_araddr,
  input  logic [2:0]  s_axilite_arprot,
  input  logic        s_axilite_arvalid,
  output logic        s_axilite_arready,
  output logic [31:0] s_axilite_rdata,
  output logic [1:0]  s_axilite_rresp,
  output logic        s_axilite_rvalid,
  input  logic        s_axilite_rready
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [1:0] RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;

  typedef enum logic {INT_IDLE, INT_PENDING} int_state_e;

  logic [CHAR_WIDTH-1:0] tx_mem_q [FIFO_DEPTH];
  logic [CHAR_WIDTH-1:0] rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d, rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [1:0]    ie_q, ie_d, bresp_q, bresp_d, rresp_q, rresp_d;
  logic [7:0]    level_q, level_d;
  logic [31:0]   rdata_q, rdata_d, status;
  logic          ovr_q, ovr_d, tx_clr_q, tx_clr_d, rx_clr_q, rx_clr_d;
  logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic          aw_hs, ar_hs, tx_push, tx_pop, rx_push, rx_pop;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [1:0]    trig;
  int_state_e    int_state_q [2];
  int_state_e    int_state_d [2];
  logic          unused_ok;

  assign unused_ok = ^{s_axilite_awprot, s_axilite_arprot, s_axilite_awaddr[31:5],
                       s_axilite_awaddr[1:0], s_axilite_araddr[31:5], s_axilite_araddr[1:0],
                       s_axilite_wdata, s_axilite_wstrb[3:1]};

  assign tx_full  = (tx_cnt_q == CW'(FIFO_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == CW'(FIFO_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign status   = {8'(rx_cnt_q), 8'(tx_cnt_q), 9'd0, int_o[1], int_o[0],
                     ovr_q, tx_full, tx_empty, rx_full, !rx_empty};

  assign s_axilite_awready = reset_ni && s_axilite_awvalid && s_axilite_wvalid && !bvalid_q;
  assign s_axilite_wready  = s_axilite_awready;
  assign s_axilite_arready = reset_ni && !rvalid_q;
  assign s_axilite_bvalid  = bvalid_q;
  assign s_axilite_bresp   = bresp_q;
  assign s_axilite_rvalid  = rvalid_q;
  assign s_axilite_rdata   = rdata_q;
  assign s_axilite_rresp   = rresp_q;
  assign aw_hs = s_axilite_awready;
  assign ar_hs = s_axilite_arready && s_axilite_arvalid;

  // Register decode, AXI response channels and FIFO pointer/count bookkeeping
  always_comb begin
    bvalid_d = bvalid_q;  bresp_d = bresp_q;
    rvalid_d = rvalid_q;  rdata_d = rdata_q;  rresp_d = rresp_q;
    ie_d = ie_q;  level_d = level_q;  ovr_d = ovr_q;
    tx_clr_d = 1'b0;  rx_clr_d = 1'b0;
    tx_push = 1'b0;  tx_pop = 1'b0;  rx_push = 1'b0;  rx_pop = 1'b0;

    if (bvalid_q && s_axilite_bready) bvalid_d = 1'b0;
    if (aw_hs) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (s_axilite_awaddr[4:2])
        3'd1: if (tx_full) ovr_d = 1'b1; else tx_push = 1'b1;
        3'd3: if (s_axilite_wstrb[0]) begin
          ie_d     = s_axilite_wdata[1:0];
          tx_clr_d = s_axilite_wdata[2];
          rx_clr_d = s_axilite_wdata[3];
          if (s_axilite_wdata[4]) ovr_d = 1'b0;
        end
        3'd5: if (rx_full) ovr_d = 1'b1; else rx_push = 1'b1;
        3'd6: if (s_axilite_wstrb[0]) level_d = s_axilite_wdata[7:0];
        3'd7: bresp_d = RESP_DECERR;
        default: bresp_d = RESP_SLVERR;
      endcase
    end

    if (rvalid_q && s_axilite_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      rdata_d  = '0;
      case (s_axilite_araddr[4:2])
        3'd0: if (!rx_empty) begin rdata_d = 32'(rx_mem_q[rx_rd_q]); rx_pop = 1'b1; end
        3'd2: rdata_d = status;
        3'd3: rdata_d = 32'(ie_q);
        3'd4: if (!tx_empty) begin rdata_d = 32'(tx_mem_q[tx_rd_q]); tx_pop = 1'b1; end
        3'd6: rdata_d = 32'(level_q);
        3'd7: rresp_d = RESP_DECERR;
        default: rresp_d = RESP_SLVERR;
      endcase
    end

    tx_wr_d = tx_push ? tx_wr_q + AW'(1) : tx_wr_q;
    tx_rd_d = tx_pop  ? tx_rd_q + AW'(1) : tx_rd_q;
    rx_wr_d = rx_push ? rx_wr_q + AW'(1) : rx_wr_q;
    rx_rd_d = rx_pop  ? rx_rd_q + AW'(1) : rx_rd_q;
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + CW'(1);
    else if (tx_pop && !tx_push) tx_cnt_d = tx_cnt_q - CW'(1);
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + CW'(1);
    else if (rx_pop && !rx_push) rx_cnt_d = rx_cnt_q - CW'(1);
    // FIFO reset lands one cycle after the CTRL write; a new write cannot
    // handshake in that cycle because its B response is still outstanding.
    if (tx_clr_q) begin tx_wr_d = '0; tx_rd_d = '0; tx_cnt_d = '0; end
    if (rx_clr_q) begin rx_wr_d = '0; rx_rd_d = '0; rx_cnt_d = '0; end

    trig[0] = ie_q[0] && rx_empty && (rx_cnt_d != '0);
    trig[1] = ie_q[1] && (32'(tx_cnt_q) < 32'(level_q)) && (32'(tx_cnt_d) >= 32'(level_q));
  end

  // Interrupt FSM next state: ack always wins, so a coincident trigger is lost
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) begin
      int_state_d[i] = int_state_q[i];
      if (int_ack_i[i])                               int_state_d[i] = INT_IDLE;
      else if (int_state_q[i] == INT_IDLE && trig[i]) int_state_d[i] = INT_PENDING;
    end
  end

  // Interrupt outputs are high exactly while pending
  always_comb begin
    for (int unsigned i = 0; i < 2; i++) int_o[i] = (int_state_q[i] == INT_PENDING);
  end

  // Interrupt FSM state register
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      int_state_q[0] <= INT_IDLE;
      int_state_q[1] <= INT_IDLE;
    end else begin
      int_state_q[0] <= int_state_d[0];
      int_state_q[1] <= int_state_d[1];
    end
  end

  // Control, status and AXI response registers
  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      tx_wr_q <= '0;  tx_rd_q <= '0;  tx_cnt_q <= '0;
      rx_wr_q <= '0;  rx_rd_q <= '0;  rx_cnt_q <= '0;
      ie_q <= '0;  level_q <= 8'(TX_THRESH);  ovr_q <= 1'b0;
      tx_clr_q <= 1'b0;  rx_clr_q <= 1'b0;
      bvalid_q <= 1'b0;  bresp_q <= '0;
      rvalid_q <= 1'b0;  rdata_q <= '0;  rresp_q <= '0;
    end else begin
      tx_wr_q <= tx_wr_d;  tx_rd_q <= tx_rd_d;  tx_cnt_q <= tx_cnt_d;
      rx_wr_q <= rx_wr_d;  rx_rd_q <= rx_rd_d;  rx_cnt_q <= rx_cnt_d;
      ie_q <= ie_d;  level_q <= level_d;  ovr_q <= ovr_d;
      tx_clr_q <= tx_clr_d;  rx_clr_q <= rx_clr_d;
      bvalid_q <= bvalid_d;  bresp_q <= bresp_d;
      rvalid_q <= rvalid_d;  rdata_q <= rdata_d;  rresp_q <= rresp_d;
    end
  end

  // FIFO storage, written only on an accepted push
  always_ff @(posedge clock_i) begin
    if (tx_push) tx_mem_q[tx_wr_q] <= s_axilite_wdata[CHAR_WIDTH-1:0];
    if (rx_push) rx_mem_q[rx_wr_q] <= s_axilite_wdata[CHAR_WIDTH-1:0];
  end
endmodule

// File: tb/tb_virtual_uart_fifo.sv
// Scenario bench for virtual_uart_fifo with default parameters.
module tb_virtual_uart_fifo;
  logic        clk = 1'b0, rst_n;
  logic [1:0]  int_o, int_ack;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  int total = 0, bad = 0;
  logic [31:0] tx_sb[$], rx_sb[$];

  always #5 clk = ~clk;

  virtual_uart_fifo #(.FIFO_DEPTH(16), .CHAR_WIDTH(8), .TX_THRESH(8)) dut (
    .clock_i(clk), .reset_ni(rst_n), .int_o(int_o), .int_ack_i(int_ack),
    .s_axilite_awaddr(awaddr), .s_axilite_awprot(3'b000), .s_axilite_awvalid(awvalid),
    .s_axilite_awready(awready), .s_axilite_wdata(wdata), .s_axilite_wstrb(wstrb),
    .s_axilite_wvalid(wvalid), .s_axilite_wready(wready), .s_axilite_bresp(bresp),
    .s_axilite_bvalid(bvalid), .s_axilite_bready(bready), .s_axilite_araddr(araddr),
    .s_axilite_arprot(3'b000), .s_axilite_arvalid(arvalid), .s_axilite_arready(arready),
    .s_axilite_rdata(rdata), .s_axilite_rresp(rresp), .s_axilite_rvalid(rvalid),
    .s_axilite_rready(rready));

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [1:0] isnap);
    int n = 0;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    #1;
    while (!(awready && wready) && n < 20) begin @(posedge clk); #2; n++; end
    if (n >= 20) begin total++; bad++; $display("FAIL write_timeout addr=%h", a); end
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; #1;
    isnap = int_o; resp = bresp;
    if (!bvalid) begin total++; bad++; $display("FAIL bvalid_late addr=%h got=0 want=1", a); end
    @(posedge clk); #1; bready = 1'b0; #1;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output logic rv);
    int n = 0;
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    #1;
    while (!arready && n < 20) begin @(posedge clk); #2; n++; end
    if (n >= 20) begin total++; bad++; $display("FAIL read_timeout addr=%h", a); end
    @(posedge clk); #1; arvalid = 1'b0; #1;
    rv = rvalid; d = rdata; resp = rresp; rready = 1'b1;
    @(posedge clk); #1; rready = 1'b0; #1;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r; logic rv;
    total++; if ({int_o, bvalid, rvalid} !== 4'b0) begin bad++;
      $display("FAIL reset_outputs got=%b want=0000", {int_o, bvalid, rvalid}); end
    axi_read(32'h08, d, r, rv);
    total++; if (d !== 32'h4 || r !== 2'b00) begin bad++;
      $display("FAIL reset_status got=%h/%0d want=00000004/0", d, r); end
    axi_read(32'h18, d, r, rv);
    total++; if (d !== 32'd8) begin bad++; $display("FAIL reset_level got=%0d want=8", d); end
  endtask

  task automatic test_tx_basic();
    logic [31:0] d, e; logic [1:0] r, s; logic rv;
    axi_write(32'h04, 32'h41, 4'hF, r, s); tx_sb.push_back(32'h41);
    axi_write(32'h04, 32'hFFFF_FF42, 4'h0, r, s); tx_sb.push_back(32'h42);
    for (int i = 0; i < 2; i++) begin
      axi_read(32'h10, d, r, rv);
      e = tx_sb.pop_front();
      total++; if (d !== e || r !== 2'b00 || rv !== 1'b1) begin bad++;
        $display("FAIL host_tx_read%0d got=%h/%0d/%b want=%h/0/1", i, d, r, rv, e); end
    end
    axi_read(32'h08, d, r, rv);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL tx_empty_status got=%h want=00000004", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d, e; logic [1:0] r, s; logic rv;
    for (int i = 0; i < 17; i++) begin
      axi_write(32'h04, 32'h10 + i, 4'hF, r, s);
      if (i < 16) tx_sb.push_back(32'h10 + i);
    end
    total++; if (r !== 2'b00) begin bad++; $display("FAIL overrun_resp got=%0d want=0", r); end
    axi_read(32'h08, d, r, rv);
    total++; if (d !== 32'h0010_0018) begin bad++;
      $display("FAIL overflow_status got=%h want=00100018", d); end
    for (int i = 0; i < 16; i++) begin
      axi_read(32'h10, d, r, rv);
      e = tx_sb.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL drain%0d got=%h want=%h", i, d, e); end
    end
    axi_write(32'h0C, 32'h10, 4'h1, r, s);
    axi_read(32'h08, d, r, rv);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL overrun_clear got=%h want=00000004", d); end
  endtask

  task automatic test_rx_int();
    logic [31:0] d, e; logic [1:0] r, s; logic rv;
    axi_write(32'h0C, 32'h1, 4'h1, r, s);
    axi_write(32'h14, 32'h55, 4'hF, r, s); rx_sb.push_back(32'h55);
    total++; if (s[0] !== 1'b1) begin bad++; $display("FAIL rx_int_rise got=%b want=1", s[0]); end
    int_ack = 2'b01; @(posedge clk); #1; int_ack = 2'b00; #1;
    total++; if (int_o[0] !== 1'b0) begin bad++; $display("FAIL rx_int_ack got=%b want=0", int_o[0]); end
    axi_read(32'h00, d, r, rv); e = rx_sb.pop_front();
    total++; if (d !== e || r !== 2'b00) begin bad++;
      $display("FAIL core_rx_read got=%h/%0d want=%h/0", d, r, e); end
    axi_read(32'h00, d, r, rv);
    total++; if (d !== 32'h0 || r !== 2'b00) begin bad++;
      $display("FAIL rx_empty_pop got=%h/%0d want=0/0", d, r); end
    axi_write(32'h0C, 32'h0, 4'h1, r, s);
  endtask

  task automatic test_tx_int();
    logic [31:0] d, e; logic [1:0] r, s; logic rv;
    axi_write(32'h18, 32'h4, 4'h1, r, s);
    axi_write(32'h0C, 32'h2, 4'h1, r, s);
    for (int i = 0; i < 4; i++) begin
      axi_write(32'h04, 32'h60 + i, 4'hF, r, s); tx_sb.push_back(32'h60 + i);
      total++; if (s[1] !== (i == 3)) begin bad++;
        $display("FAIL tx_int_push%0d got=%b want=%b", i, s[1], i == 3); end
    end
    // ack and the 5th push share one clock edge
    awaddr = 32'h04; wdata = 32'h64; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bready = 1'b1; int_ack = 2'b10; tx_sb.push_back(32'h64);
    #1;
    total++; if (awready !== 1'b1) begin bad++; $display("FAIL ack_push_ready got=%b want=1", awready); end
    @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0; int_ack = 2'b00;
    repeat (3) @(posedge clk);
    #1; bready = 1'b0; #1;
    total++; if (int_o[1] !== 1'b0) begin bad++; $display("FAIL tx_int_after_ack got=%b want=0", int_o[1]); end
    for (int i = 0; i < 5; i++) begin
      axi_read(32'h10, d, r, rv); e = tx_sb.pop_front();
      total++; if (d !== e) begin bad++; $display("FAIL tx_int_drain%0d got=%h want=%h", i, d, e); end
    end
    axi_write(32'h0C, 32'h0, 4'h1, r, s);
    axi_write(32'h18, 32'h8, 4'h1, r, s);
  endtask

  task automatic test_errors();
    logic [31:0] d; logic [1:0] r, s; logic rv; logic seen;
    axi_read(32'h1C, d, r, rv);
    total++; if (r !== 2'b11 || d !== 32'h0) begin bad++;
      $display("FAIL decerr_read got=%0d/%h want=3/0", r, d); end
    axi_read(32'h04, d, r, rv);
    total++; if (r !== 2'b10) begin bad++; $display("FAIL slverr_read got=%0d want=2", r); end
    axi_write(32'hFFFF_FF1C, 32'h1, 4'hF, r, s);
    total++; if (r !== 2'b11) begin bad++; $display("FAIL decerr_write got=%0d want=3", r); end
    axi_write(32'h10, 32'h77, 4'hF, r, s);
    total++; if (r !== 2'b10) begin bad++; $display("FAIL slverr_write got=%0d want=2", r); end
    axi_read(32'h28, d, r, rv);
    total++; if (d !== 32'h4 || r !== 2'b00) begin bad++;
      $display("FAIL alias_status got=%h/%0d want=00000004/0", d, r); end
    awaddr = 32'h04; awvalid = 1'b1; wvalid = 1'b0; seen = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #2; if (awready) seen = 1'b1; end
    awvalid = 1'b0; #1;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL aw_alone got=1 want=0"); end
  endtask

  task automatic test_fifo_reset();
    logic [31:0] d, e; logic [1:0] r, s; logic rv;
    for (int i = 0; i < 3; i++) axi_write(32'h04, 32'h90 + i, 4'hF, r, s);
    axi_write(32'h0C, 32'h4, 4'h1, r, s);
    axi_read(32'h08, d, r, rv);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL tx_fifo_reset got=%h want=00000004", d); end
    axi_write(32'h18, 32'h33, 4'h2, r, s);
    axi_read(32'h18, d, r, rv);
    total++; if (d !== 32'd8) begin bad++; $display("FAIL level_wstrb got=%0d want=8", d); end
    axi_write(32'h04, 32'hA1, 4'hF, r, s); tx_sb.push_back(32'hA1);
    axi_read(32'h10, d, r, rv); e = tx_sb.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL post_reset_fifo got=%h want=%h", d, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r, s; logic rv;
    axi_write(32'h18, 32'h3, 4'h1, r, s);
    axi_write(32'h04, 32'h5A, 4'hF, r, s);
    araddr = 32'h08; arvalid = 1'b1; rready = 1'b0; #1;
    @(posedge clk); #1; arvalid = 1'b0; #1;
    total++; if (rvalid !== 1'b1) begin bad++; $display("FAIL mid_rvalid got=%b want=1", rvalid); end
    rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1; #1;
    total++; if (rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b want=0", rvalid); end
    axi_read(32'h08, d, r, rv);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL reset_mid_status got=%h want=00000004", d); end
    axi_read(32'h18, d, r, rv);
    total++; if (d !== 32'd8) begin bad++; $display("FAIL reset_mid_level got=%0d want=8", d); end
  endtask

  initial begin
    rst_n = 1'b0; int_ack = 2'b00;
    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1; #1;
    test_reset();
    test_tx_basic();
    test_overflow();
    test_rx_int();
    test_tx_int();
    test_errors();
    test_fifo_reset();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
